// File: rtl/debounce_pkg.sv
// ----------------------------------------------------------------------------
// debounce_pkg
//   Shared types and defaults for the input debouncer family.
//   - debounce_state_t : debouncer FSM states
//   - DEF_STABLE_CYCLES: default number of agreeing samples to accept a change
// ----------------------------------------------------------------------------
package debounce_pkg;

    typedef enum logic [1:0] {
        ST_LOW   = 2'd0,
        CHK_HIGH = 2'd1,
        ST_HIGH  = 2'd2,
        CHK_LOW  = 2'd3
    } debounce_state_t;

    localparam int DEF_STABLE_CYCLES = 4;

endpackage

// File: rtl/sync_2ff.sv
// ----------------------------------------------------------------------------
// sync_2ff
//   Two-flop synchroniser for a single asynchronous bit. Both flops reset to 0.
//   Ports:
//     clk   : clock (rising edge)
//     rst_n : synchronous active-low reset
//     d     : asynchronous input
//     q     : synchronised output, 2 cycles of latency
// ----------------------------------------------------------------------------
module sync_2ff (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= d;
            r_sync <= r_meta;
        end
    end

    assign q = r_sync;

endmodule

// File: rtl/input_debouncer.sv
// ----------------------------------------------------------------------------
// input_debouncer
//   Turns a raw, possibly bouncing single-bit input into a stable level. A new
//   value must be seen on STABLE_CYCLES consecutive clock edges before the
//   debounced level follows it; each accepted change emits a registered
//   one-cycle rise or fall pulse in the same cycle level changes.
//
//   Optional feature macro: INPUT_DEBOUNCER_SYNC_EN
//     defined   : a passes through sync_2ff first (+2 cycles latency)
//     undefined : a is sampled directly and must be synchronous to clk
//
//   Parameters:
//     STABLE_CYCLES : consecutive agreeing samples to accept a change (>= 2)
//   Ports:
//     clk   : clock (rising edge)
//     rst_n : synchronous active-low reset
//     a     : raw input
//     level : debounced level (registered)
//     rise  : one-cycle pulse on accepted 0->1 (registered)
//     fall  : one-cycle pulse on accepted 1->0 (registered)
// ----------------------------------------------------------------------------
module input_debouncer
    import debounce_pkg::*;
#(
    parameter int STABLE_CYCLES = DEF_STABLE_CYCLES
) (
    input  logic clk,
    input  logic rst_n,
    input  logic a,
    output logic level,
    output logic rise,
    output logic fall
);

    // Guarded so an illegal STABLE_CYCLES still yields a legal width before
    // the elaboration error below fires.
    localparam int CNT_W = (STABLE_CYCLES < 2) ? 1 : $clog2(STABLE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

    generate
        if (STABLE_CYCLES < 2) begin : g_bad_param
            $error("input_debouncer: STABLE_CYCLES must be >= 2");
        end
    endgenerate

    // ------------------------------------------------------------------------
    // Sample source
    // ------------------------------------------------------------------------
    logic w_s;

`ifdef INPUT_DEBOUNCER_SYNC_EN
    sync_2ff u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (a),
        .q     (w_s)
    );
`else
    assign w_s = a;
`endif

    // ------------------------------------------------------------------------
    // FSM state and registered outputs
    // ------------------------------------------------------------------------
    debounce_state_t  r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_level;
    logic             r_rise;
    logic             r_fall;

    debounce_state_t  w_state_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             w_level_nxt;
    logic             w_rise_nxt;
    logic             w_fall_nxt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_LOW;
            r_cnt   <= '0;
            r_level <= 1'b0;
            r_rise  <= 1'b0;
            r_fall  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_level <= w_level_nxt;
            r_rise  <= w_rise_nxt;
            r_fall  <= w_fall_nxt;
        end
    end

    // The edge that leaves ST_* is the first agreeing sample, so the check
    // starts at cnt=1 and completes on the sample where cnt already equals
    // STABLE_CYCLES-1. cnt holds its value while in ST_* (don't-care there).
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_level_nxt = r_level;
        w_rise_nxt  = 1'b0;
        w_fall_nxt  = 1'b0;

        case (r_state)
            ST_LOW: begin
                if (w_s) begin
                    w_state_nxt = CHK_HIGH;
                    w_cnt_nxt   = CNT_W'(1);
                end
            end
            CHK_HIGH: begin
                if (!w_s) begin
                    w_state_nxt = ST_LOW;
                end else if (r_cnt == CNT_LAST) begin
                    w_state_nxt = ST_HIGH;
                    w_level_nxt = 1'b1;
                    w_rise_nxt  = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            ST_HIGH: begin
                if (!w_s) begin
                    w_state_nxt = CHK_LOW;
                    w_cnt_nxt   = CNT_W'(1);
                end
            end
            CHK_LOW: begin
                if (w_s) begin
                    w_state_nxt = ST_HIGH;
                end else if (r_cnt == CNT_LAST) begin
                    w_state_nxt = ST_LOW;
                    w_level_nxt = 1'b0;
                    w_fall_nxt  = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            default: begin
                w_state_nxt = ST_LOW;
                w_level_nxt = 1'b0;
            end
        endcase
    end

    assign level = r_level;
    assign rise  = r_rise;
    assign fall  = r_fall;

endmodule

// File: tb/tb_input_debouncer.sv
// ----------------------------------------------------------------------------
// tb_input_debouncer
//   Directed scenarios with literal expectations, then randomized input with
//   occasional resets, all compared every cycle against a run-length model.
// ----------------------------------------------------------------------------
module tb_input_debouncer;

    localparam int N = 4;
`ifdef INPUT_DEBOUNCER_SYNC_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic a = 1'b0;
    logic level, rise, fall;

    int n_vec = 0;
    int n_err = 0;
    bit cmp_en = 1'b0;

    input_debouncer #(.STABLE_CYCLES(N)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .a     (a),
        .level (level),
        .rise  (rise),
        .fall  (fall)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    // Level follows the sample stream once N consecutive samples disagree
    // with it; the run length restarts after every accepted change.
    logic m_s1, m_s2, m_level, m_rise, m_fall;
    int   m_run;
    logic m_s;
    assign m_s = (LAT == 2) ? m_s2 : a;

    always @(posedge clk) begin
        if (!rst_n) begin
            m_s1 <= 1'b0; m_s2 <= 1'b0;
            m_level <= 1'b0; m_rise <= 1'b0; m_fall <= 1'b0;
            m_run <= 0;
        end else begin
            m_s1 <= a;
            m_s2 <= m_s1;
            m_rise <= 1'b0;
            m_fall <= 1'b0;
            if (m_s != m_level) begin
                if (m_run + 1 == N) begin
                    m_level <= ~m_level;
                    m_rise  <= ~m_level;
                    m_fall  <= m_level;
                    m_run   <= 0;
                end else begin
                    m_run <= m_run + 1;
                end
            end else begin
                m_run <= 0;
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (cmp_en) begin
            n_vec++;
            if (level !== m_level || rise !== m_rise || fall !== m_fall) begin
                n_err++;
                $display("FAIL model t=%0t: dut l/r/f=%b%b%b model=%b%b%b",
                         $time, level, rise, fall, m_level, m_rise, m_fall);
            end
        end
    end

    // ---------------- helpers ----------------
    // Inputs applied at a falling edge; returns at the next falling edge.
    task automatic tick(input logic av, input logic rv);
        a = av;
        rst_n = rv;
        @(negedge clk);
    endtask

    task automatic chk(input string nm, input logic [2:0] got, input logic [2:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s t=%0t: level/rise/fall got %b expected %b", nm, $time, got, exp);
        end
    endtask

    initial begin
        @(negedge clk);
        cmp_en = 1'b1;

        // 1. reset held with a=1, then 3 quiet cycles after release
        for (int i = 0; i < 2; i++) begin
            tick(1'b1, 1'b0);
            chk("reset_hold", {level, rise, fall}, 3'b000);
        end
        for (int i = 0; i < 3; i++) begin
            tick(1'b1, 1'b1);
            chk("post_reset", {level, rise, fall}, 3'b000);
        end
        // 2. clean rise on the 4th sampling edge (+LAT)
        for (int i = 0; i < LAT; i++) begin
            tick(1'b1, 1'b1);
            chk("rise_wait", {level, rise, fall}, 3'b000);
        end
        tick(1'b1, 1'b1);
        chk("rise_pulse", {level, rise, fall}, 3'b110);
        tick(1'b1, 1'b1);
        chk("rise_after", {level, rise, fall}, 3'b100);

        // 4. clean fall
        for (int i = 0; i < 3 + LAT; i++) begin
            tick(1'b0, 1'b1);
            chk("fall_wait", {level, rise, fall}, 3'b100);
        end
        tick(1'b0, 1'b1);
        chk("fall_pulse", {level, rise, fall}, 3'b001);
        tick(1'b0, 1'b1);
        chk("fall_after", {level, rise, fall}, 3'b000);

        // 3. bounce 1,1,1,0,1,1,1,1 then hold 1
        for (int i = 1; i <= 9 + LAT; i++) begin
            tick((i == 4) ? 1'b0 : 1'b1, 1'b1);
            chk("bounce", {level, rise, fall},
                {(i >= 8 + LAT), (i == 8 + LAT), 1'b0});
        end

        // 4b. single-cycle 0 glitch from level=1
        for (int i = 1; i <= 7 + LAT; i++) begin
            tick((i == 1) ? 1'b0 : 1'b1, 1'b1);
            chk("glitch", {level, rise, fall}, 3'b100);
        end

        // back to level 0
        for (int i = 0; i < N + LAT + 2; i++) tick(1'b0, 1'b1);
        chk("to_low", {level, rise, fall}, 3'b000);

        // 5. reset mid-check
        for (int i = 0; i < 3; i++) begin
            tick(1'b1, 1'b1);
            chk("mid_pre", {level, rise, fall}, 3'b000);
        end
        tick(1'b1, 1'b0);
        chk("mid_rst", {level, rise, fall}, 3'b000);
        for (int j = 1; j <= N + LAT + 1; j++) begin
            tick(1'b1, 1'b1);
            chk("mid_post", {level, rise, fall}, {(j >= N + LAT), (j == N + LAT), 1'b0});
        end

        // randomized: held values of random length, rare resets
        for (int k = 0; k < 600; k++) begin
            logic v;
            int   len;
            v   = 1'($urandom_range(0, 1));
            len = $urandom_range(1, 2 * N + 1);
            for (int j = 0; j < len; j++)
                tick(v, ($urandom_range(0, 99) != 0));
        end

        cmp_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/input_debouncer.md
# input_debouncer

Cleans a raw, possibly bouncing or asynchronous single-bit input into a stable level that feeds the edge and pulse detectors. The block optionally synchronises the input, then requires it to hold a new value for `STABLE_CYCLES` consecutive clock edges before the debounced level changes. Each accepted change also produces a registered one-cycle `rise` or `fall` pulse. `level` connects directly to the `a` input of the downstream `posedge_detector` or `one_cycle_pulse_detector`.

## Interface
- `STABLE_CYCLES`, default 4: number of consecutive agreeing samples needed to accept a change. Must be ≥2; a smaller value is an elaboration error.
- `CNT_W`, default `$clog2(STABLE_CYCLES)`: counter width. Derived localparam; not overridable.
- `clk`, input, 1: single clock; all logic is rising-edge.
- `rst_n`, input, 1: reset, synchronous, active-low.
- `a`, input, 1: raw input (asynchronous when the sync feature is enabled).
- `level`, output, 1: debounced level, registered.
- `rise`, output, 1: one-cycle pulse when `level` goes 0→1, registered.
- `fall`, output, 1: one-cycle pulse when `level` goes 1→0, registered.

## Operation
- Sample `s`: the synchronised `a` (see Configuration), otherwise `a` itself.
- The FSM has four states:
  - `ST_LOW`: `level`=0. If `s`=1, go to `CHK_HIGH` and set `cnt`←1.
  - `CHK_HIGH`: `level`=0.
    - If `s`=0, go to `ST_LOW` (abort, no pulse).
    - Else if `cnt`==`STABLE_CYCLES`-1, go to `ST_HIGH`, set `level`←1 and `rise`←1.
    - Else `cnt`←`cnt`+1.
  - `ST_HIGH`: `level`=1. If `s`=0, go to `CHK_LOW` and set `cnt`←1.
  - `CHK_LOW`: mirror of `CHK_HIGH`. On abort return to `ST_HIGH`; on completion go to `ST_LOW`, set `level`←0 and `fall`←1.
- The run of agreeing samples must be consecutive. Any disagreeing sample aborts the check, and the next check restarts with `cnt`=1.
- `rise` and `fall` are cleared every cycle unless set as above. They are never both 1, and never 1 on consecutive cycles.
- `cnt` never exceeds `STABLE_CYCLES`-1. It is don't-care in `ST_*` states and holds its last value there.
- Reset (`rst_n`=0 at a rising edge):
  - state←`ST_LOW`, `cnt`←0, `level`←0, `rise`←0, `fall`←0, sync flops←0.
  - Reset overrides any transition in the same cycle.
  - Reset during `CHK_*` discards the partial count and emits no pulse.

## Timing
- Without sync: `a` changes before edge k and stays stable → `level`, `rise`/`fall` update at edge k+`STABLE_CYCLES`-1. They are visible in the cycle after `STABLE_CYCLES` sampling edges.
- With sync: the same timing plus 2 cycles.
- `rise`/`fall` are asserted in the same cycle that `level` first shows its new value.
- Minimum spacing between accepted changes is `STABLE_CYCLES` cycles.
- An input glitch shorter than `STABLE_CYCLES` cycles never reaches `level`.
- No combinational path from `a` to any output.

## Configuration
- Macro: `INPUT_DEBOUNCER_SYNC_EN`.
- Defined: `a` passes through a two-flop synchroniser (reset to 0) before the FSM, adding 2 cycles of latency. Use this for pins and other asynchronous sources.
- Undefined: the FSM samples `a` directly. `a` must then be synchronous to `clk`.

## Structure
- Shared package `debounce_pkg` holds:
  - the `debounce_state_t` enum (`ST_LOW`, `CHK_HIGH`, `ST_HIGH`, `CHK_LOW`);
  - the default `STABLE_CYCLES` localparam.
- Sub-module `sync_2ff` (clk, rst_n, d, q) is instantiated only under `INPUT_DEBOUNCER_SYNC_EN`. It is reusable elsewhere.

## Test plan
All scenarios use `STABLE_CYCLES`=4 with the macro undefined unless noted.
1. Reset: hold `rst_n`=0 for 2 cycles with `a`=1 → `level`=0, `rise`=0, `fall`=0 throughout, and for 3 cycles after release.
2. Clean rise: after reset, `a`=1 held → `level`=1 and `rise`=1 in the same cycle, exactly after the 4th sampling edge. `rise`=0 the next cycle.
3. Bounce rejection: `a` sequence 1,1,1,0,1,1,1,1 → no `rise` after the first three 1s; `rise` only after the final four 1s.
4. Clean fall: from `level`=1, `a`=0 held for 4 cycles → `fall`=1 for one cycle and `level`=0. A single-cycle 0 glitch leaves `level`=1.
5. Reset mid-check: `a`=1 for 3 cycles, then `rst_n`=0 for 1 cycle, with `a` kept at 1 → no `rise` at the would-be 4th edge. `rise` fires 4 edges after reset release.
6. Macro defined: repeat scenario 2 → `rise` occurs exactly 2 cycles later than in the undefined build.
